// File: rtl/counter_defs.sv
// Shared constants and elaboration helpers for the synchronous up/down counter family.
package counter_defs;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;
    localparam bit DIR_DOWN  = 1'b0;
    localparam bit DIR_UP    = 1'b1;

    // Bits needed to hold 0..v-1, never less than one so a degenerate counter still elaborates.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the enabled cycle that closes each period.
module tick_prescaler
    import counter_defs::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int PW = clog2(PRESCALE);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p;

    // With PRESCALE=1, p is pinned at 0 so tick degenerates to en.
    assign tick = en && (p == P_LAST);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset || clear) begin
            p <= '0;
        end else if (tick) begin
            p <= '0;
        end else if (en) begin
            p <= p + 1'b1;
        end
    end

endmodule

// File: rtl/sync_updown_counter.sv
// Fully synchronous modulo-N up/down counter with load, enable, wrap/saturate and prescaler.
module sync_updown_counter
    import counter_defs::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter bit     SATURATE = MODE_WRAP,
    parameter int     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("sync_updown_counter: WIDTH must be 2..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("sync_updown_counter: MODULUS must be 2..2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("sync_updown_counter: PRESCALE must be 1..65535");
    end

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    logic             tick;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             sat_next;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (load),
        .tick  (tick)
    );

    assign tc = (up_dn == DIR_UP) ? (q == Q_MAX) : (q == '0);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        q_next    = q;
        wrap_next = 1'b0;
        sat_next  = sat;
        if (load) begin
            q_next   = (load_val > Q_MAX) ? Q_MAX : load_val;
            sat_next = 1'b0;
        end else if (tick) begin
            if (up_dn == DIR_UP) begin
                if (q != Q_MAX) begin
                    q_next   = q + 1'b1;
                    sat_next = 1'b0;
                end else if (SATURATE == MODE_SAT) begin
                    sat_next = 1'b1;
                end else begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (q != '0) begin
                    q_next   = q - 1'b1;
                    sat_next = 1'b0;
                end else if (SATURATE == MODE_SAT) begin
                    sat_next = 1'b1;
                end else begin
                    q_next    = Q_MAX;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
            sat  <= sat_next;
        end
    end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench: four counter configurations share one stimulus bus; each step queues the
// hand-computed expectation for one of them and a negedge monitor pops and compares.
module tb_sync_updown_counter;

    typedef struct {
        string name;
        int    dut;
        int    q;
        bit    wrap;
        bit    sat;
        bit    tc;
    } exp_t;

    localparam int D_WRAP = 0;
    localparam int D_SAT  = 1;
    localparam int D_LOAD = 2;
    localparam int D_PRE  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;

    logic [3:0] q_w, q_s, q_p;
    logic [7:0] q_l;
    logic       tc_w, tc_s, tc_l, tc_p;
    logic       wrap_w, wrap_s, wrap_l, wrap_p;
    logic       sat_w, sat_s, sat_l, sat_p;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[3:0]),
        .q(q_w), .tc(tc_w), .wrap(wrap_w), .sat(sat_w));

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[3:0]),
        .q(q_s), .tc(tc_s), .wrap(wrap_s), .sat(sat_s));

    sync_updown_counter #(.WIDTH(8), .MODULUS(100), .SATURATE(1'b0), .PRESCALE(1)) u_load (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .q(q_l), .tc(tc_l), .wrap(wrap_l), .sat(sat_l));

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[3:0]),
        .q(q_p), .tc(tc_p), .wrap(wrap_p), .sat(sat_p));

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: inputs stay stable from just after negedge to just after the next negedge,
    // so the combinational tc read here belongs to the same step as the queued entry.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            int   aq;
            bit   aw, as, at;
            e = sb.pop_front();
            case (e.dut)
                D_WRAP:  begin aq = int'(q_w); aw = wrap_w; as = sat_w; at = tc_w; end
                D_SAT:   begin aq = int'(q_s); aw = wrap_s; as = sat_s; at = tc_s; end
                D_LOAD:  begin aq = int'(q_l); aw = wrap_l; as = sat_l; at = tc_l; end
                default: begin aq = int'(q_p); aw = wrap_p; as = sat_p; at = tc_p; end
            endcase
            check({e.name, ".q"},    aq,      e.q);
            check({e.name, ".wrap"}, int'(aw), int'(e.wrap));
            check({e.name, ".sat"},  int'(as), int'(e.sat));
            check({e.name, ".tc"},   int'(at), int'(e.tc));
        end
    end

    // Apply inputs, let one rising edge pass, queue what the chosen DUT must show afterwards.
    task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv,
                        input int d, input int eq, input bit ew, input bit es, input bit etc,
                        input string nm);
        exp_t x;
        reset    = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = 8'(lv);
        @(posedge clk);
        #1;
        x = '{name: nm, dut: d, q: eq, wrap: ew, sat: es, tc: etc};
        sb.push_back(x);
        @(negedge clk);
        #1;
    endtask

    int pre_en[11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int pre_q[11]  = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

    initial begin
        // Reset held with en=1: nothing moves.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, D_WRAP, 0, 0, 0, 0, "reset_hold");

        // Wrap up through MODULUS=10: 1..9, 0 (wrap pulse), 1.
        for (int i = 1; i <= 11; i++)
            step(0, 1, 1, 0, 0, D_WRAP, i % 10, i == 10, 0, (i % 10) == 9, "wrap_up");

        // Wrap down from 0 to MODULUS-1, then en=0 holds and clears wrap.
        step(0, 0, 0, 1, 1, D_WRAP, 1, 0, 0, 0, "load_1");
        step(0, 1, 0, 0, 0, D_WRAP, 0, 0, 0, 1, "down_to_0");
        step(0, 1, 0, 0, 0, D_WRAP, 9, 1, 0, 0, "wrap_down");
        step(0, 0, 0, 0, 0, D_WRAP, 9, 0, 0, 0, "en_off_hold");

        // Saturate at 0, release upward, saturate at top, load clears sat.
        step(0, 0, 0, 1, 2, D_SAT, 2, 0, 0, 0, "sat_load2");
        step(0, 1, 0, 0, 0, D_SAT, 1, 0, 0, 0, "sat_down1");
        step(0, 1, 0, 0, 0, D_SAT, 0, 0, 0, 1, "sat_down0");
        step(0, 1, 0, 0, 0, D_SAT, 0, 0, 1, 1, "sat_hold_lo");
        step(0, 1, 0, 0, 0, D_SAT, 0, 0, 1, 1, "sat_hold_lo2");
        step(0, 1, 1, 0, 0, D_SAT, 1, 0, 0, 0, "sat_release");
        step(0, 0, 1, 1, 9, D_SAT, 9, 0, 0, 1, "sat_load9");
        step(0, 1, 1, 0, 0, D_SAT, 9, 0, 1, 1, "sat_hold_hi");
        step(0, 0, 1, 1, 4, D_SAT, 4, 0, 0, 0, "sat_load_clr");

        // Load clamp, load beats count, en=0 hold, wrap at 99.
        step(0, 0, 1, 1, 200, D_LOAD, 99, 0, 0, 1, "load_clamp");
        step(0, 0, 1, 1, 5,   D_LOAD, 5,  0, 0, 0, "load_5");
        step(0, 1, 1, 1, 42,  D_LOAD, 42, 0, 0, 0, "load_over_en");
        step(0, 0, 1, 0, 0,   D_LOAD, 42, 0, 0, 0, "load_en_off");
        step(0, 1, 1, 1, 99,  D_LOAD, 99, 0, 0, 1, "load_99");
        step(0, 1, 1, 0, 0,   D_LOAD, 0,  1, 0, 0, "load_wrap99");

        // Prescaler divide-by-3 with an en gap that must keep the phase.
        step(1, 0, 1, 0, 0, D_PRE, 0, 0, 0, 0, "pre_reset");
        for (int i = 0; i < 11; i++)
            step(0, pre_en[i][0], 1, 0, 0, D_PRE, pre_q[i], 0, 0, 0, "pre_count");

        // Mid-count reset with p=1 must clear the prescaler too.
        step(0, 0, 1, 1, 7, D_PRE, 7, 0, 0, 0, "pre_load7");
        step(0, 1, 1, 0, 0, D_PRE, 7, 0, 0, 0, "pre_p1");
        step(1, 1, 1, 0, 0, D_PRE, 0, 0, 0, 0, "pre_midreset");
        step(0, 1, 1, 0, 0, D_PRE, 0, 0, 0, 0, "pre_after_rst1");
        step(0, 1, 1, 0, 0, D_PRE, 0, 0, 0, 0, "pre_after_rst2");
        step(0, 1, 1, 0, 0, D_PRE, 1, 0, 0, 0, "pre_after_rst3");

        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
